// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end of the processor, sitting upstream of Control_Unit. It owns the
// program counter, fetches one 8-bit instruction at a time over a simple
// req/ready instruction-memory port, holds it in the instruction register
// and splits it into a 3-bit opcode and a 5-bit operand. Each fetched
// instruction is handed on with a single-cycle issue strobe (o_En), which
// Control_Unit uses to register the opcode.
//
// Build option:
//   JUMP_EN  when defined, opcode 3'b111 is an unconditional jump that is
//            consumed here: no issue strobe, PC is loaded from the operand.
//            When undefined, 3'b111 is issued like any other opcode.
//
// Parameters:
//   ADDR_W    PC / instruction-address width (1..5); PC wraps modulo 2^ADDR_W
//   RESET_PC  PC value loaded by reset
//
// Ports:
//   i_Clk         clock, all state changes on the rising edge
//   i_Reset       synchronous, active-high reset
//   i_Run         level: 1 = keep fetching, 0 = go idle after current instr
//   i_Stall       downstream hold; blocks issue while high
//   o_Imem_req    fetch request, held until accepted
//   o_Imem_addr   fetch address (= PC), stable while o_Imem_req is high
//   i_Imem_ready  memory accepts the request; i_Imem_rdata valid same cycle
//   i_Imem_rdata  instruction {opcode[7:5], operand[4:0]}
//   o_Opcode      IR[7:5] to Control_Unit
//   o_Operand     IR[4:0] to the datapath
//   o_En          one-cycle issue strobe to Control_Unit
//   o_PC          current program counter
//   o_Busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Run,
  input  logic              i_Stall,
  output logic              o_Imem_req,
  output logic [ADDR_W-1:0] o_Imem_addr,
  input  logic              i_Imem_ready,
  input  logic [7:0]        i_Imem_rdata,
  output logic [2:0]        o_Opcode,
  output logic [4:0]        o_Operand,
  output logic              o_En,
  output logic [ADDR_W-1:0] o_PC,
  output logic              o_Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } stateT;

  localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PcOne   = ADDR_W'(1);

  stateT             r_state;
  stateT             w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic              w_accept;
  logic              w_leaveIssue;
  logic              w_isJump;
  logic [ADDR_W-1:0] w_pcNext;

  // A fetch completes in the cycle the memory raises ready while we request.
  assign w_accept     = (r_state == S_FETCH) && i_Imem_ready;

  // The instruction leaves ISSUE on the first cycle without a stall; this is
  // the single point where PC advances and Run is re-examined.
  assign w_leaveIssue = (r_state == S_ISSUE) && !i_Stall;

`ifdef JUMP_EN
  // Jumps are resolved locally and never reach Control_Unit.
  assign w_isJump = (r_ir[7:5] == 3'b111);
`else
  assign w_isJump = 1'b0;
`endif

  // Jump target is the low ADDR_W bits of the operand; otherwise PC+1, which
  // wraps naturally because the adder is only ADDR_W bits wide.
  always_comb begin
    w_pcNext = r_pc + PcOne;
    if (w_isJump) begin
      w_pcNext = r_ir[ADDR_W-1:0];
    end
  end

  // State register. Reset wins over everything, including a fetch in
  // flight, so a pending request simply disappears at that edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Run is only looked at in IDLE and when leaving ISSUE;
  // an outstanding fetch always runs to completion.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_Run) begin
          w_nextState = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_Imem_ready) begin
          w_nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_Stall) begin
          w_nextState = i_Run ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Program counter and instruction register. IR only changes on a
  // completed fetch, so opcode/operand hold steady between captures.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_pc <= PcReset;
      r_ir <= 8'h00;
    end else begin
      if (w_accept) begin
        r_ir <= i_Imem_rdata;
      end
      if (w_leaveIssue) begin
        r_pc <= w_pcNext;
      end
    end
  end

  // Output logic. En is combinational from state and Stall so that the
  // strobe lines up with the cycle the instruction actually leaves ISSUE;
  // since ISSUE is always followed by FETCH or IDLE it can never last two
  // cycles in a row.
  always_comb begin
    o_Imem_req = 1'b0;
    o_En       = 1'b0;
    o_Busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_Busy = 1'b0;
      end
      S_FETCH: begin
        o_Imem_req = 1'b1;
      end
      S_ISSUE: begin
        o_En = !i_Stall && !w_isJump;
      end
      default: begin
        o_Busy = 1'b0;
      end
    endcase
  end

  assign o_Imem_addr = r_pc;
  assign o_PC        = r_pc;
  assign o_Opcode    = r_ir[7:5];
  assign o_Operand   = r_ir[4:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit with a behavioural instruction memory
// (per-address wait states) and a scoreboard of expected issued
// instructions. Inputs change 2 time units after the rising edge or at the
// falling edge; outputs are sampled on the falling edge.
// Honours JUMP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int AddrW = 5;

  typedef struct {
    logic [2:0] opcode;
    logic [4:0] operand;
    logic [4:0] pc;
  } expT;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Run = 1'b0;
  logic             Stall = 1'b0;
  logic             Imem_req;
  logic [AddrW-1:0] Imem_addr;
  logic             Imem_ready;
  logic [7:0]       Imem_rdata;
  logic [2:0]       Opcode;
  logic [4:0]       Operand;
  logic             En;
  logic [AddrW-1:0] PC;
  logic             Busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32];
  int         waitTab [32];
  int         waitCount = 0;
  expT        expQ [$];
  logic       prevEn = 1'b0;

`ifdef JUMP_EN
  localparam bit JumpBuild = 1'b1;
`else
  localparam bit JumpBuild = 1'b0;
`endif

  instr_fetch_unit #(.ADDR_W(AddrW), .RESET_PC(0)) dut (
    .i_Clk        (Clk),
    .i_Reset      (Reset),
    .i_Run        (Run),
    .i_Stall      (Stall),
    .o_Imem_req   (Imem_req),
    .o_Imem_addr  (Imem_addr),
    .i_Imem_ready (Imem_ready),
    .i_Imem_rdata (Imem_rdata),
    .o_Opcode     (Opcode),
    .o_Operand    (Operand),
    .o_En         (En),
    .o_PC         (PC),
    .o_Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // Memory model: accepts a request once it has waited waitTab[addr] cycles.
  assign Imem_ready = Imem_req && (waitCount >= waitTab[Imem_addr]);
  assign Imem_rdata = mem[Imem_addr];

  always @(posedge Clk) begin
    waitCount <= (Imem_req && !Imem_ready) ? waitCount + 1 : 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic reset, input logic run, input logic stall);
    Reset = reset;
    Run   = run;
    Stall = stall;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  // Leaves the bench in the first cycle after reset with Reset released.
  task automatic doReset();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
  endtask

  task automatic pushExp(input int addr);
    expT e;
    e.opcode  = mem[addr][7:5];
    e.operand = mem[addr][4:0];
    e.pc      = 5'(addr);
    expQ.push_back(e);
  endtask

  // Every issue strobe is matched against the next scoreboard entry.
  always @(negedge Clk) begin
    if (En === 1'b1) begin
      checkOutput("en_not_back_to_back", {31'd0, prevEn}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_issue_pc", {27'd0, PC}, 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("issue_opcode", {29'd0, Opcode}, {29'd0, e.opcode});
        checkOutput("issue_operand", {27'd0, Operand}, {27'd0, e.operand});
        checkOutput("issue_pc", {27'd0, PC}, {27'd0, e.pc});
      end
    end
    prevEn = (En === 1'b1);
  end

  initial begin
    int nextAddr;
    int idlePc;

    for (int i = 0; i < 32; i++) begin
      mem[i]     = {3'(i % 7), 5'(i)};
      waitTab[i] = 0;
    end
    mem[0] = 8'h25;
    mem[1] = 8'hC3;
    mem[2] = 8'h41;
    mem[31] = 8'h20;

    // Reset state and back-to-back fetches with zero-wait memory.
    $display("[TB] basic fetch/issue");
    doReset();
    sample();
    checkOutput("rst_req", {31'd0, Imem_req}, 32'd0);
    checkOutput("rst_pc", {27'd0, PC}, 32'd0);
    checkOutput("rst_opcode", {29'd0, Opcode}, 32'd0);
    checkOutput("rst_operand", {27'd0, Operand}, 32'd0);
    checkOutput("rst_en", {31'd0, En}, 32'd0);
    checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
    pushExp(0);
    pushExp(1);
    pushExp(2);
    Run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) Run = 1'b0;
      sample();
      checkOutput("t1_en_pattern", {31'd0, En}, {31'd0, (i % 2) == 0});
      checkOutput("t1_req_pattern", {31'd0, Imem_req}, {31'd0, (i % 2) == 1});
    end
    tick();
    sample();
    checkOutput("t1_pc_end", {27'd0, PC}, 32'd3);
    checkOutput("t1_busy_end", {31'd0, Busy}, 32'd0);
    checkOutput("t1_req_end", {31'd0, Imem_req}, 32'd0);

    // Three wait states on address 1.
    $display("[TB] wait states");
    waitTab[1] = 3;
    doReset();
    pushExp(0);
    pushExp(1);
    Run = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 7) Run = 1'b0;
      sample();
      if (i >= 3 && i <= 6) begin
        checkOutput("t2_req_held", {31'd0, Imem_req}, 32'd1);
        checkOutput("t2_addr_held", {27'd0, Imem_addr}, 32'd1);
        checkOutput("t2_no_en", {31'd0, En}, 32'd0);
      end
      if (i == 7) checkOutput("t2_en_after_ready", {31'd0, En}, 32'd1);
    end
    waitTab[1] = 0;
    tick();
    sample();
    checkOutput("t2_busy_end", {31'd0, Busy}, 32'd0);
    checkOutput("t2_pc_end", {27'd0, PC}, 32'd2);

    // Four stalled cycles in ISSUE, then a single release strobe.
    $display("[TB] stall");
    pushExp(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    sample();
    checkOutput("t3_fetch_req", {31'd0, Imem_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      checkOutput("t3_stall_en", {31'd0, En}, 32'd0);
      checkOutput("t3_stall_pc", {27'd0, PC}, 32'd2);
      checkOutput("t3_stall_busy", {31'd0, Busy}, 32'd1);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    sample();
    checkOutput("t3_release_en", {31'd0, En}, 32'd1);
    checkOutput("t3_release_pc", {27'd0, PC}, 32'd2);
    tick();
    sample();
    checkOutput("t3_pc_after", {27'd0, PC}, 32'd3);
    checkOutput("t3_en_after", {31'd0, En}, 32'd0);

    // Run through to address 31 and wrap; Run drops during the wrapped fetch.
    $display("[TB] pc wrap");
    for (int k = 3; k < 32; k++) pushExp(k);
    pushExp(0);
    Run = 1'b1;
    repeat (58) tick();
    tick();
    Run = 1'b0;
    sample();
    checkOutput("t4_wrap_req", {31'd0, Imem_req}, 32'd1);
    checkOutput("t4_wrap_addr", {27'd0, Imem_addr}, 32'd0);
    checkOutput("t4_wrap_pc", {27'd0, PC}, 32'd0);
    tick();
    sample();
    checkOutput("t4_last_en", {31'd0, En}, 32'd1);
    tick();
    sample();
    checkOutput("t4_idle_busy", {31'd0, Busy}, 32'd0);
    checkOutput("t4_idle_req", {31'd0, Imem_req}, 32'd0);
    checkOutput("t4_idle_pc", {27'd0, PC}, 32'd1);

    // Opcode 111 at address 4: a jump or an ordinary issue depending on build.
    $display("[TB] opcode 111");
    mem[4] = 8'hEA;
    nextAddr = JumpBuild ? 10 : 5;
    doReset();
    for (int k = 0; k < 4; k++) pushExp(k);
    if (!JumpBuild) pushExp(4);
    Run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      sample();
    end
    checkOutput("t5_en", {31'd0, En}, {31'd0, !JumpBuild});
    checkOutput("t5_opcode", {29'd0, Opcode}, 32'd7);
    checkOutput("t5_operand", {27'd0, Operand}, 32'h0A);
    pushExp(nextAddr);
    tick();
    Run = 1'b0;
    sample();
    checkOutput("t5_next_addr", {27'd0, Imem_addr}, nextAddr);
    checkOutput("t5_next_req", {31'd0, Imem_req}, 32'd1);
    tick();
    sample();
    tick();
    sample();
    checkOutput("t5_idle_busy", {31'd0, Busy}, 32'd0);
    checkOutput("t5_idle_pc", {27'd0, PC}, nextAddr + 1);

    // Reset while a fetch is waiting on memory.
    $display("[TB] reset during fetch");
    idlePc = nextAddr + 1;
    for (int i = 0; i < 32; i++) waitTab[i] = 20;
    Run = 1'b1;
    tick();
    tick();
    sample();
    checkOutput("t6_req_pending", {31'd0, Imem_req}, 32'd1);
    checkOutput("t6_pc_pending", {27'd0, PC}, idlePc);
    Reset = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    sample();
    checkOutput("t6_req", {31'd0, Imem_req}, 32'd0);
    checkOutput("t6_pc", {27'd0, PC}, 32'd0);
    checkOutput("t6_en", {31'd0, En}, 32'd0);
    checkOutput("t6_busy", {31'd0, Busy}, 32'd0);
    checkOutput("t6_opcode", {29'd0, Opcode}, 32'd0);
    checkOutput("t6_operand", {27'd0, Operand}, 32'd0);
    for (int i = 0; i < 32; i++) waitTab[i] = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      checkOutput("t6_stay_idle", {31'd0, Busy}, 32'd0);
      checkOutput("t6_no_capture", {24'd0, Opcode, Operand}, 32'd0);
    end

    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
